// File: rtl/cpu_mem_access_master_pkg.sv
// Shared definitions for the CPU-side memory access master.
// Holds the default widths, the default timeout and the FSM state encoding
// used by cpu_mem_access_master and its timeout counter.
package cpu_mem_access_master_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LEN_WIDTH  = 4;
  localparam int DEF_TO_WIDTH   = 8;
  localparam int DEF_TO_CYCLES  = 200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // waiting for a host command
    ST_FETCH = 3'd1,  // waiting for the next write-data beat
    ST_REQ   = 3'd2,  // request outstanding at the controller
    ST_RSP   = 3'd3,  // read beat presented to the host
    ST_GAP   = 3'd4,  // mandatory low cycle on cpuMemReq between words
    ST_DONE  = 3'd5   // completion pulse
  } state_e;

endpackage

// File: rtl/cpu_mem_access_master_timeout.sv
// cpu_mem_timeout_cnt: cycle counter that watches an outstanding request.
// Ports:
//   clk, rst  - core clock, synchronous active-high reset
//   clear     - force the count back to zero (has priority over enable)
//   enable    - count one cycle
//   expire    - high while enabled and the count has reached TO_CYCLES-1
module cpu_mem_timeout_cnt
  import cpu_mem_access_master_pkg::*;
#(
  parameter int TO_WIDTH  = DEF_TO_WIDTH,
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in an always_comb gets a default on its first
  // line, so no path through the block leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + TO_WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == TO_WIDTH'(TO_CYCLES - 1));

endmodule

// File: rtl/cpu_mem_access_master.sv
// cpu_mem_access_master: turns host block commands (start address + length)
// into single-word cpuMemReq/cpuMemAck transactions on the CPU-side port of a
// dual-port memory controller.
// Ports:
//   clockCore, resetCore           - core clock, synchronous active-high reset
//   cmdValid/cmdReady/cmdRd/cmdAddr/cmdLen
//                                  - host command; burst is cmdLen+1 words
//   wdValid/wdReady/wdData         - write-data beats from the host
//   rspValid/rspReady/rspData/rspLast
//                                  - read-data beats to the host
//   doneValid/doneErr              - completion pulse, doneErr = timeout abort
//   staleAck                       - sticky flag: ack with no request pending
//   cpuMemReq/Rd/Addr/WrData       - request side of the controller port
//   cpuMemAck/cpuMemRdData         - completion side of the controller port
module cpu_mem_access_master
  import cpu_mem_access_master_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int TO_WIDTH   = DEF_TO_WIDTH,
  parameter int TO_CYCLES  = DEF_TO_CYCLES
) (
  input  logic                  clockCore,
  input  logic                  resetCore,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic                  cmdRd,
  input  logic [ADDR_WIDTH-1:0] cmdAddr,
  input  logic [LEN_WIDTH-1:0]  cmdLen,
  input  logic                  wdValid,
  output logic                  wdReady,
  input  logic [DATA_WIDTH-1:0] wdData,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic                  rspLast,
  output logic                  doneValid,
  output logic                  doneErr,
  output logic                  staleAck,
  output logic                  cpuMemReq,
  output logic                  cpuMemRd,
  output logic [ADDR_WIDTH-1:0] cpuMemAddr,
  output logic [DATA_WIDTH-1:0] cpuMemWrData,
  input  logic                  cpuMemAck,
  input  logic [DATA_WIDTH-1:0] cpuMemRdData
);

  state_e                state_q, state_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  err_q, err_d;
  logic                  stale_q, stale_d;

  logic to_clear, to_enable, to_expire;
  logic cmd_accept;

  // The counter only runs while a request is outstanding; an ack restarts it
  // so the next word gets a full timeout window.
  assign to_enable = (state_q == ST_REQ);
  assign to_clear  = (state_q != ST_REQ) || cpuMemAck;

  cpu_mem_timeout_cnt #(
    .TO_WIDTH  (TO_WIDTH),
    .TO_CYCLES (TO_CYCLES)
  ) u_timeout (
    .clk    (clockCore),
    .rst    (resetCore),
    .clear  (to_clear),
    .enable (to_enable),
    .expire (to_expire)
  );

  assign cmd_accept = cmdValid && cmdReady;

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    wr_data_d  = wr_data_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    // Any ack that does not complete an outstanding request is flagged and
    // otherwise ignored.
    stale_d    = stale_q || (cpuMemAck && (state_q != ST_REQ));

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          rd_d       = cmdRd;
          addr_d     = cmdAddr;
          beat_cnt_d = cmdLen;
          err_d      = 1'b0;
          state_d    = cmdRd ? ST_REQ : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (wdValid) begin
          wr_data_d = wdData;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack is checked first so an ack on the expiry cycle completes normally.
        if (cpuMemAck) begin
          if (rd_q) begin
            rsp_data_d = cpuMemRdData;
            state_d    = ST_RSP;
          end else begin
            state_d = ST_GAP;
          end
        end else if (to_expire) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RSP: begin
        if (rspReady) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (beat_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          addr_d     = addr_q + ADDR_WIDTH'(1);
          beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
          state_d    = rd_q ? ST_REQ : ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      state_q    <= ST_IDLE;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      wr_data_q  <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      wr_data_q  <= wr_data_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      stale_q    <= stale_d;
    end
  end

  // cmdReady is masked during reset so every output reads 0 while resetCore
  // is held, and no command can be accepted on a reset edge.
  assign cmdReady     = (state_q == ST_IDLE) && !resetCore;
  assign wdReady      = (state_q == ST_FETCH);
  assign rspValid     = (state_q == ST_RSP);
  assign rspLast      = rspValid && (beat_cnt_q == '0);
  assign rspData      = rsp_data_q;
  assign doneValid    = (state_q == ST_DONE);
  assign doneErr      = doneValid && err_q;
  assign staleAck     = stale_q;
  // Request is decoded from the state register, so it is glitch-free and
  // drops in the cycle after the ack (or expiry).
  assign cpuMemReq    = (state_q == ST_REQ);
  assign cpuMemRd     = rd_q;
  assign cpuMemAddr   = addr_q;
  assign cpuMemWrData = wr_data_q;

endmodule

// File: tb/tb_cpu_mem_access_master.sv
module tb_cpu_mem_access_master;

  logic        clockCore = 1'b0;
  logic        resetCore;
  logic        cmdValid, cmdReady, cmdRd;
  logic [7:0]  cmdAddr;
  logic [3:0]  cmdLen;
  logic        wdValid, wdReady;
  logic [15:0] wdData;
  logic        rspValid, rspReady, rspLast;
  logic [15:0] rspData;
  logic        doneValid, doneErr, staleAck;
  logic        cpuMemReq, cpuMemRd, cpuMemAck;
  logic [7:0]  cpuMemAddr;
  logic [15:0] cpuMemWrData;
  logic [15:0] cpuMemRdData;

  always #5 clockCore = ~clockCore;

  cpu_mem_access_master dut (
    .clockCore    (clockCore),
    .resetCore    (resetCore),
    .cmdValid     (cmdValid),
    .cmdReady     (cmdReady),
    .cmdRd        (cmdRd),
    .cmdAddr      (cmdAddr),
    .cmdLen       (cmdLen),
    .wdValid      (wdValid),
    .wdReady      (wdReady),
    .wdData       (wdData),
    .rspValid     (rspValid),
    .rspReady     (rspReady),
    .rspData      (rspData),
    .rspLast      (rspLast),
    .doneValid    (doneValid),
    .doneErr      (doneErr),
    .staleAck     (staleAck),
    .cpuMemReq    (cpuMemReq),
    .cpuMemRd     (cpuMemRd),
    .cpuMemAddr   (cpuMemAddr),
    .cpuMemWrData (cpuMemWrData),
    .cpuMemAck    (cpuMemAck),
    .cpuMemRdData (cpuMemRdData)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- controller model ----------------
  // Memory content is a fixed function of the address: {8'h5A, addr}.
  typedef struct {
    logic        rd;
    logic [7:0]  addr;
    logic [15:0] data;
  } obs_t;

  obs_t obs_q[$];
  obs_t cur;
  logic model_ack     = 1'b0;
  logic manual_ack    = 1'b0;
  logic req_prev      = 1'b0;
  logic busy          = 1'b0;
  logic ack_enable    = 1'b1;
  int   ack_delay     = 4;
  int   wait_cnt      = 0;
  int   stab_err      = 0;
  logic [15:0] model_rd_data = 16'h0;

  assign cpuMemAck    = model_ack | manual_ack;
  assign cpuMemRdData = model_rd_data;

  always @(posedge clockCore) begin
    model_ack <= 1'b0;
    req_prev  <= cpuMemReq;
    if (resetCore) begin
      busy <= 1'b0;
    end else begin
      if (cpuMemReq && req_prev &&
          (cpuMemAddr != cur.addr || cpuMemRd != cur.rd || (!cur.rd && cpuMemWrData != cur.data)))
        stab_err <= stab_err + 1;
      if (cpuMemReq && !req_prev) begin
        cur <= '{cpuMemRd, cpuMemAddr, cpuMemWrData};
        obs_q.push_back('{cpuMemRd, cpuMemAddr, cpuMemWrData});
        if (ack_enable) begin
          busy     <= 1'b1;
          wait_cnt <= ack_delay - 1;
        end
      end else if (busy) begin
        if (wait_cnt == 0) begin
          model_ack     <= 1'b1;
          model_rd_data <= {8'h5A, cpuMemAddr};
          busy          <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end
    end
  end

  // ---------------- burst driver ----------------
  int          n_rsp, n_wd, n_req;
  logic        done_seen, done_err;
  logic [15:0] rsp_data_log [32];
  logic        rsp_last_log [32];

  function automatic logic [63:0] outs();
    return {15'd0, cmdReady, wdReady, rspValid, rspLast, doneValid, doneErr, staleAck,
            cpuMemReq, cpuMemRd, cpuMemAddr, cpuMemWrData, rspData};
  endfunction

  // Drives one command to completion. wd_stall / rsp_stall hold wdValid /
  // rspReady low for that many cycles on the first FETCH / RSP cycle.
  task automatic run_burst(input logic rd, input logic [7:0] addr, input logic [3:0] len,
                           input logic [15:0] wbase, input int wd_stall, input int rsp_stall,
                           input logic [15:0] hold_exp);
    logic cmd_pend, fetch_started, rsp_started;
    int   wd_hold, rsp_hold;
    cmd_pend = 1'b1; fetch_started = 1'b0; rsp_started = 1'b0;
    wd_hold = 0; rsp_hold = 0;
    n_rsp = 0; n_wd = 0; n_req = 0; done_seen = 1'b0; done_err = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      @(negedge clockCore);
      cmdValid = cmd_pend; cmdRd = rd; cmdAddr = addr; cmdLen = len;
      if (cmd_pend && cmdReady) cmd_pend = 1'b0;
      if (cpuMemReq) n_req++;

      if (wdReady && !fetch_started) begin
        fetch_started = 1'b1;
        wd_hold = wd_stall;
      end
      if (wd_hold > 0) begin
        wdValid = 1'b0;
        check("starve_req_low", cpuMemReq, 0);
        check("starve_wd_ready", wdReady, 1);
        wd_hold--;
      end else begin
        wdValid = !rd;
        wdData  = wbase + 16'(n_wd);
        if (wdValid && wdReady) n_wd++;
      end

      if (rspValid && !rsp_started) begin
        rsp_started = 1'b1;
        rsp_hold = rsp_stall;
      end
      if (rsp_hold > 0) begin
        rspReady = 1'b0;
        check("bp_rsp_valid", rspValid, 1);
        check("bp_rsp_data", rspData, hold_exp);
        check("bp_req_low", cpuMemReq, 0);
        rsp_hold--;
      end else begin
        rspReady = 1'b1;
        if (rspValid) begin
          if (n_rsp < 32) begin
            rsp_data_log[n_rsp] = rspData;
            rsp_last_log[n_rsp] = rspLast;
          end
          n_rsp++;
        end
      end

      if (doneValid) begin
        done_seen = 1'b1;
        done_err  = doneErr;
        wdValid   = 1'b0;
        rspReady  = 1'b0;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [15:0] wbase;
    int          ack_dly;
    int          beats;
    logic [7:0]  last_addr;
    logic [15:0] last_data;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] ea;
    logic       saw_done, saw_req;

    vecs[0] = '{1'b0, 8'h10, 4'd2,  16'hA001, 4,   3,  8'h12, 16'hA003}; // write burst
    vecs[1] = '{1'b1, 8'hFE, 4'd2,  16'h0000, 4,   3,  8'h00, 16'h5A00}; // read with wrap
    vecs[2] = '{1'b1, 8'h40, 4'd0,  16'h0000, 2,   1,  8'h40, 16'h5A40}; // single read
    vecs[3] = '{1'b0, 8'hF8, 4'd15, 16'h1000, 1,   16, 8'h07, 16'h100F}; // max length + wrap
    vecs[4] = '{1'b0, 8'h70, 4'd0,  16'h7070, 198, 1,  8'h70, 16'h7070}; // ack on expiry cycle

    resetCore = 1'b1;
    cmdValid = 1'b0; cmdRd = 1'b0; cmdAddr = '0; cmdLen = '0;
    wdValid = 1'b0; wdData = '0; rspReady = 1'b0;

    repeat (3) @(negedge clockCore);
    check("reset_outs_zero", outs(), 64'h0);
    resetCore = 1'b0;
    @(negedge clockCore);
    check("post_reset_idle", outs(), 64'h0001_0000_0000_0000);

    for (int v = 0; v < 5; v++) begin
      ack_delay = vecs[v].ack_dly;
      obs_q.delete();
      run_burst(vecs[v].rd, vecs[v].addr, vecs[v].len, vecs[v].wbase, 0, 0, 16'h0);
      check("vec_done_seen", done_seen, 1);
      check("vec_done_err", done_err, 0);
      check("vec_n_words", obs_q.size(), vecs[v].beats);
      check("vec_n_rsp", n_rsp, vecs[v].rd ? vecs[v].beats : 0);
      for (int i = 0; i < vecs[v].beats && i < obs_q.size(); i++) begin
        ea = vecs[v].addr + 8'(i);
        check("vec_addr", obs_q[i].addr, ea);
        check("vec_rd", obs_q[i].rd, vecs[v].rd);
        if (!vecs[v].rd) begin
          check("vec_wdata", obs_q[i].data, vecs[v].wbase + 16'(i));
        end else if (i < n_rsp) begin
          check("vec_rdata", rsp_data_log[i], {8'h5A, ea});
          check("vec_rsp_last", rsp_last_log[i], (i == vecs[v].beats - 1));
        end
      end
      if (obs_q.size() >= vecs[v].beats) begin
        check("vec_last_addr", obs_q[vecs[v].beats-1].addr, vecs[v].last_addr);
        if (vecs[v].rd) check("vec_last_rdata", rsp_data_log[vecs[v].beats-1], vecs[v].last_data);
        else            check("vec_last_wdata", obs_q[vecs[v].beats-1].data, vecs[v].last_data);
      end
    end
    check("ack_on_expiry_req_cycles", n_req, 200);
    check("stability", stab_err, 0);
    check("no_stale_yet", staleAck, 0);

    // Read backpressure: first beat held for 10 cycles with no new request.
    ack_delay = 3;
    obs_q.delete();
    run_burst(1'b1, 8'h20, 4'd1, 16'h0, 0, 10, 16'h5A20);
    check("bp_done", done_seen, 1);
    check("bp_n_rsp", n_rsp, 2);
    check("bp_rdata0", rsp_data_log[0], 16'h5A20);
    check("bp_rdata1", rsp_data_log[1], 16'h5A21);
    check("bp_last0", rsp_last_log[0], 0);
    check("bp_last1", rsp_last_log[1], 1);
    check("bp_n_words", obs_q.size(), 2);

    // Write starvation: 20 idle cycles in FETCH must not eat the timeout
    // budget, so a 190-cycle ack latency still completes cleanly.
    ack_delay = 190;
    obs_q.delete();
    run_burst(1'b0, 8'h50, 4'd0, 16'hC050, 20, 0, 16'h0);
    check("starve_done", done_seen, 1);
    check("starve_err", done_err, 0);
    check("starve_n_words", obs_q.size(), 1);
    if (obs_q.size() > 0) check("starve_wdata", obs_q[0].data, 16'hC050);

    // Timeout: controller never acks; second write beat stays with the host.
    ack_enable = 1'b0;
    obs_q.delete();
    run_burst(1'b0, 8'h30, 4'd1, 16'hB030, 0, 0, 16'h0);
    check("to_done", done_seen, 1);
    check("to_err", done_err, 1);
    check("to_req_cycles", n_req, 200);
    check("to_wd_taken", n_wd, 1);
    check("to_n_words", obs_q.size(), 1);
    repeat (4) @(negedge clockCore);
    check("stale_before", staleAck, 0);
    manual_ack = 1'b1;
    @(negedge clockCore);
    manual_ack = 1'b0;
    check("stale_set", staleAck, 1);
    check("stale_no_done", doneValid, 0);
    check("stale_no_rsp", rspValid, 0);
    check("stale_idle", cmdReady, 1);
    check("stale_no_req", cpuMemReq, 0);
    ack_enable = 1'b1;

    // Reset in the middle of a read request.
    ack_delay = 50;
    @(negedge clockCore);
    cmdValid = 1'b1; cmdRd = 1'b1; cmdAddr = 8'h60; cmdLen = 4'd3;
    @(negedge clockCore);
    cmdValid = 1'b0;
    check("rst_pre_req", cpuMemReq, 1);
    repeat (3) @(negedge clockCore);
    resetCore = 1'b1;
    @(negedge clockCore);
    check("rst_outs_zero", outs(), 64'h0);
    resetCore = 1'b0;
    @(negedge clockCore);
    check("rst_cmd_ready", outs(), 64'h0001_0000_0000_0000);
    saw_done = 1'b0;
    saw_req  = 1'b0;
    repeat (30) begin
      @(negedge clockCore);
      if (doneValid) saw_done = 1'b1;
      if (cpuMemReq) saw_req = 1'b1;
    end
    check("rst_no_done", saw_done, 0);
    check("rst_no_req", saw_req, 0);
    check("rst_no_stale", staleAck, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
